ps2_device_tx: RTL and testbench
================================

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 1000, meaning CLK_25MHZ cycles per PS/2 clock half-phase (12.5 kHz at 25 MHz); legal range >= 2.
REQ-002 SHALL have parameter GAP_CYCLES, default 2500, meaning idle cycles (both lines high) after each frame; legal range >= 1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK_25MHZ  input  1  sole clock; all logic on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 SCAN_VALID  input  1  SCAN_DATA holds a byte to send.
REQ-007 SCAN_DATA  input  8  scan-code byte.
REQ-008 SCAN_READY  output  1  high when the FIFO can accept a byte.
REQ-009 PS2_CLK  output  1  device-driven PS/2 clock to the host receiver.
REQ-010 PS2_DATA  output  1  device-driven PS/2 data to the host receiver.
REQ-011 BUSY  output  1  high while a frame is in progress or the FIFO is non-empty.

Function
REQ-012 SHALL accept a byte only on a cycle where SCAN_VALID and SCAN_READY are both 1; SCAN_VALID while SCAN_READY=0 is ignored with no side effect.
REQ-013 SHALL buffer accepted bytes in a 4-entry FIFO, sent in acceptance order; SCAN_READY = not full.
REQ-014 SHALL allow push and pop in the same cycle when not full; SCAN_READY SHALL rise the cycle after a pop from full.
REQ-015 SHALL send each byte as an 11-bit frame: start 0, data LSB first, odd parity (~^data), stop 1.
REQ-016 SHALL implement states IDLE, BIT_HI, BIT_LO, GAP.
REQ-017 IDLE: PS2_CLK=1, PS2_DATA=1; when FIFO non-empty, pop, load frame, bit index 0, go to BIT_HI.
REQ-018 BIT_HI: PS2_CLK=1, PS2_DATA = frame bit[index]; lasts exactly HALF_PERIOD cycles, then BIT_LO.
REQ-019 BIT_LO: PS2_CLK=0, PS2_DATA unchanged; lasts exactly HALF_PERIOD cycles; then index 10 -> GAP, else index+1 -> BIT_HI.
REQ-020 GAP: PS2_CLK=1, PS2_DATA=1 for exactly GAP_CYCLES cycles, then IDLE.
REQ-021 PS2_DATA SHALL change only at BIT_HI entry (PS2_CLK high), giving HALF_PERIOD cycles of setup before and hold after each falling edge.
REQ-022 A frame SHALL last 22*HALF_PERIOD cycles plus GAP_CYCLES; 11 falling edges per frame, no glitches.
REQ-023 Latency: byte accepted in cycle N with IDLE and FIFO empty -> PS2_DATA=0 first seen in cycle N+2.
REQ-024 Back-to-back bytes SHALL be separated by exactly GAP_CYCLES plus one IDLE cycle.
REQ-025 Outputs SHALL be registered; PS2_CLK/PS2_DATA are push-pull, no tristate.

Reset
REQ-026 While RESET=1: PS2_CLK=1, PS2_DATA=1, SCAN_READY=0, BUSY=0, state IDLE, FIFO emptied, counters 0.
REQ-027 RESET mid-frame SHALL abort the frame; both lines high on the next cycle, no partial frame resumes, and queued bytes are discarded.
REQ-028 SCAN_READY SHALL be 1 in the first cycle after RESET deasserts.

Verification
REQ-029 Send 0x1C, HALF_PERIOD=4, GAP_CYCLES=6 -> sampled at falling edges: 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame 88 cycles + 6 gap.
REQ-030 Send 0xF0 then 0x00 back-to-back -> two frames, parity 1 each, stop-to-start separation exactly 7 cycles (GAP+1 IDLE).
REQ-031 Push 5 bytes with SCAN_VALID held high while idle -> 1 popped immediately, 4 queued; 5th accepted only after the next pop (SCAN_READY 0->1); all 5 sent in order.
REQ-032 Assert RESET at bit index 5 of 0xFF with 2 queued -> lines high next cycle, BUSY=0, no further falling edges; after release SCAN_READY=1.
REQ-033 Default parameters, send 0xAA -> PS2_CLK period 2000 cycles, 50% duty, PS2_DATA stable +/-1000 cycles around each falling edge; parity 1.
REQ-034 SCAN_VALID pulses with SCAN_READY=0 (FIFO full) -> no byte stored, none sent beyond the 4 queued.

Source files
------------

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scan-code bytes in a 4-entry FIFO and
// serialises each as an 11-bit frame on push-pull PS2_CLK/PS2_DATA lines.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 1000,
  parameter int GAP_CYCLES  = 2500
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       SCAN_VALID,
  input  logic [7:0] SCAN_DATA,
  output logic       SCAN_READY,
  output logic       PS2_CLK,
  output logic       PS2_DATA,
  output logic       BUSY
);

  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [10:0]   frame;

  logic [7:0]    mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic [2:0]    count_next;

  logic          push;
  logic          pop;
  logic          half_done;
  logic          gap_done;
  logic          busy_next;

  // SCAN_READY is the registered "not full" flag, so it also gates acceptance.
  always_comb begin
    push       = SCAN_VALID && SCAN_READY;
    pop        = (state == IDLE) && (count != 3'd0);
    count_next = count + 3'(push) - 3'(pop);
    half_done  = (cnt == HALF_LAST);
    gap_done   = (cnt == GAP_LAST);
    busy_next  = pop || (count_next != 3'd0) || (state == BIT_HI) ||
                 (state == BIT_LO) || ((state == GAP) && !gap_done);
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge CLK_25MHZ) begin
    if (push) mem[wr_ptr] <= SCAN_DATA;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the values from before the edge, independent of statement order.
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame      <= '1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      SCAN_READY <= 1'b0;
      BUSY       <= 1'b0;
      PS2_CLK    <= 1'b1;
      PS2_DATA   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count      <= count_next;
      SCAN_READY <= (count_next != 3'd4);
      BUSY       <= busy_next;

      case (state)
        IDLE: begin
          PS2_CLK  <= 1'b1;
          PS2_DATA <= 1'b1;
          if (pop) begin
            frame    <= {1'b1, ~^mem[rd_ptr], mem[rd_ptr], 1'b0};
            PS2_DATA <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            state    <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (half_done) begin
            cnt     <= '0;
            PS2_CLK <= 1'b0;
            state   <= BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_LO: begin
          if (half_done) begin
            cnt     <= '0;
            PS2_CLK <= 1'b1;
            if (idx == 4'd10) begin
              PS2_DATA <= 1'b1;
              state    <= GAP;
            end else begin
              // Data moves only here, together with the rising clock.
              idx      <= idx + 4'd1;
              frame    <= {1'b1, frame[10:1]};
              PS2_DATA <= frame[1];
              state    <= BIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: a byte-queue model of accepted data
// and a line-level frame decoder that checks timing, parity and order.
`timescale 1ns/1ps
module tb_ps2_device_tx;

  localparam int HP  = 4;
  localparam int GP  = 6;
  localparam int HP2 = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, ps2c, ps2d, busy;
  logic       valid2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       ready2, ps2c2, ps2d2, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GP)) dut (
    .CLK_25MHZ(clk), .RESET(rst), .SCAN_VALID(valid), .SCAN_DATA(data),
    .SCAN_READY(ready), .PS2_CLK(ps2c), .PS2_DATA(ps2d), .BUSY(busy)
  );

  ps2_device_tx dut2 (
    .CLK_25MHZ(clk), .RESET(rst), .SCAN_VALID(valid2), .SCAN_DATA(data2),
    .SCAN_READY(ready2), .PS2_CLK(ps2c2), .PS2_DATA(ps2d2), .BUSY(busy2)
  );

  // Reference: a byte is accepted when VALID and READY meet outside reset;
  // accepted bytes must come out as frames in the same order.
  logic [7:0] exp_q[$];

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid && ready) exp_q.push_back(data);
    end
  end

  // Line monitor for the small-parameter instance.
  logic        pc = 1'b1, pd = 1'b1;
  int          nbits = 0, falls = 0, frames_done = 0;
  int          last_fall = 0, last_hi = 0, start_cyc = 0, last_end = 0, last_sep = 0;
  logic [10:0] bits = '0, last_bits = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        nbits = 0;
        pc = 1'b1;
        pd = 1'b1;
      end else begin
        if (ps2d !== pd) begin
          n_checks++;
          if (!(ps2c === 1'b1 && (pc === 1'b0 || nbits == 0))) begin
            n_fail++;
            $display("FAIL data_change: PS2_DATA went %b at cycle %0d with PS2_CLK %b, required only at clock-high entry", ps2d, cyc, ps2c);
          end
          if (nbits == 0 && ps2d === 1'b0) begin
            start_cyc = cyc;
            last_hi   = cyc;
            last_sep  = cyc - last_end;
          end
        end
        if (pc === 1'b1 && ps2c === 1'b0) begin
          n_checks++;
          if (cyc - last_hi != HP) begin
            n_fail++;
            $display("FAIL high_phase: %0d cycles, required %0d", cyc - last_hi, HP);
          end
          if (nbits > 0) begin
            n_checks++;
            if (cyc - last_fall != 2 * HP) begin
              n_fail++;
              $display("FAIL clk_period: %0d cycles, required %0d", cyc - last_fall, 2 * HP);
            end
          end
          if (nbits < 11) bits[nbits] = ps2d;
          nbits++;
          falls++;
          last_fall = cyc;
          if (nbits == 11) begin
            logic [7:0] e;
            last_bits = bits;
            n_checks++;
            if (bits[0] !== 1'b0 || bits[10] !== 1'b1 || ($countones(bits[9:1]) % 2) != 1) begin
              n_fail++;
              $display("FAIL frame_format: got %b, required start 0, odd parity, stop 1", bits);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL frame_order: got unexpected byte %h, required no frame", bits[8:1]);
            end else begin
              e = exp_q.pop_front();
              if (bits !== exp_frame(e)) begin
                n_fail++;
                $display("FAIL frame_order: got frame %b, required %b", bits, exp_frame(e));
              end
            end
          end
        end
        if (pc === 1'b0 && ps2c === 1'b1) begin
          n_checks++;
          if (cyc - last_fall != HP) begin
            n_fail++;
            $display("FAIL low_phase: %0d cycles, required %0d", cyc - last_fall, HP);
          end
          last_hi = cyc;
          if (nbits == 11) begin
            n_checks++;
            if (cyc - start_cyc != 22 * HP) begin
              n_fail++;
              $display("FAIL frame_length: %0d cycles, required %0d", cyc - start_cyc, 22 * HP);
            end
            last_end = cyc;
            frames_done++;
            nbits = 0;
          end
        end
        pc = ps2c;
        pd = ps2d;
      end
    end
  end

  // Line monitor for the default-parameter instance.
  logic        pc2 = 1'b1, pd2 = 1'b1;
  int          nb2 = 0, last_fall2 = 0, last_hi2 = 0;
  logic [10:0] bits2 = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        nb2 = 0;
        pc2 = 1'b1;
        pd2 = 1'b1;
      end else begin
        if (ps2d2 !== pd2) begin
          n_checks++;
          if (!(ps2c2 === 1'b1 && (pc2 === 1'b0 || nb2 == 0))) begin
            n_fail++;
            $display("FAIL data_change_dflt: PS2_DATA went %b at cycle %0d with PS2_CLK %b", ps2d2, cyc, ps2c2);
          end
          if (nb2 == 0 && ps2d2 === 1'b0) last_hi2 = cyc;
        end
        if (pc2 === 1'b1 && ps2c2 === 1'b0) begin
          n_checks++;
          if (cyc - last_hi2 != HP2) begin
            n_fail++;
            $display("FAIL setup_dflt: %0d cycles, required %0d", cyc - last_hi2, HP2);
          end
          if (nb2 > 0) begin
            n_checks++;
            if (cyc - last_fall2 != 2 * HP2) begin
              n_fail++;
              $display("FAIL period_dflt: %0d cycles, required %0d", cyc - last_fall2, 2 * HP2);
            end
          end
          if (nb2 < 11) bits2[nb2] = ps2d2;
          nb2++;
          last_fall2 = cyc;
        end
        if (pc2 === 1'b0 && ps2c2 === 1'b1) begin
          n_checks++;
          if (cyc - last_fall2 != HP2) begin
            n_fail++;
            $display("FAIL hold_dflt: %0d cycles, required %0d", cyc - last_fall2, HP2);
          end
          last_hi2 = cyc;
        end
        pc2 = ps2c2;
        pd2 = ps2d2;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int t = 0;
    while (frames_done < target && t < budget) begin
      tick();
      t++;
    end
    n_checks++;
    if (frames_done < target) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d frames, required %0d", name, frames_done, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      tick();
      t++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: BUSY got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({ps2c, ps2d, ready, busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_state: clk,data,ready,busy got %b, required 1100", {ps2c, ps2d, ready, busy});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({ready, busy, ready2} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_release: ready,busy,ready2 got %b, required 101", {ready, busy, ready2});
    end
  endtask

  task automatic test_single_latency();
    int f0 = frames_done;
    valid = 1'b1;
    data  = 8'h1C;
    tick();
    valid = 1'b0;
    n_checks++;
    if (ps2d !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_n1: PS2_DATA got %b, required 1", ps2d);
    end
    tick();
    n_checks++;
    if (ps2d !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_n2: data,busy got %b%b, required 01", ps2d, busy);
    end
    wait_frames(f0 + 1, 200, "single");
    n_checks++;
    if (last_bits !== 11'b10000111000) begin
      n_fail++;
      $display("FAIL single_bits: got %b, required 10000111000", last_bits);
    end
    wait_idle(50, "single");
  endtask

  task automatic test_back_to_back();
    int f0 = frames_done;
    valid = 1'b1;
    data  = 8'hF0;
    tick();
    data = 8'h00;
    tick();
    valid = 1'b0;
    wait_frames(f0 + 2, 400, "b2b");
    n_checks++;
    if (last_sep != GP + 1) begin
      n_fail++;
      $display("FAIL b2b_separation: got %0d cycles, required %0d", last_sep, GP + 1);
    end
    n_checks++;
    if (last_bits[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_parity: got %b, required 1", last_bits[9]);
    end
    wait_idle(50, "b2b");
  endtask

  task automatic test_fill_and_full();
    int f0 = frames_done;
    int t  = 0;
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'h31 + 8'(i);
      tick();
    end
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: SCAN_READY got %b, required 0", ready);
    end
    // Pulses against a full FIFO must leave no trace.
    for (int i = 0; i < 3; i++) begin
      data  = 8'hE0 + 8'(i);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_pulse: SCAN_READY got %b, required 0", ready);
      end
    end
    data  = 8'h77;
    valid = 1'b1;
    while (ready !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    n_checks++;
    if (ready !== 1'b1 || frames_done != f0 + 1) begin
      n_fail++;
      $display("FAIL fill_reopen: ready %b frames %0d, required 1 and %0d", ready, frames_done - f0, 1);
    end
    tick();
    valid = 1'b0;
    wait_frames(f0 + 6, 900, "fill");
    wait_idle(200, "fill");
    n_checks++;
    if (frames_done != f0 + 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_count: got %0d frames %0d pending, required 6 and 0", frames_done - f0, exp_q.size());
    end
  endtask

  task automatic test_random();
    int f0 = frames_done;
    int t;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b0;
      tick($urandom_range(0, 3));
      data  = 8'($urandom);
      valid = 1'b1;
      t = 0;
      while (ready !== 1'b1 && t < 500) begin
        tick();
        t++;
      end
      tick();
    end
    valid = 1'b0;
    wait_frames(f0 + 10, 2000, "random");
    wait_idle(50, "random");
    n_checks++;
    if (frames_done != f0 + 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_count: got %0d frames %0d pending, required 10 and 0", frames_done - f0, exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int t = 0;
    int f_snap;
    int d_snap;
    valid = 1'b1;
    data = 8'hFF; tick();
    data = 8'hA5; tick();
    data = 8'h3C; tick();
    valid = 1'b0;
    while (nbits != 5 && t < 200) begin
      tick();
      t++;
    end
    tick(HP + 1);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({ps2c, ps2d, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL abort_lines: clk,data,busy got %b, required 110", {ps2c, ps2d, busy});
    end
    exp_q.delete();
    rst = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: SCAN_READY got %b, required 1", ready);
    end
    f_snap = falls;
    d_snap = frames_done;
    tick(400);
    n_checks++;
    if (falls != f_snap || frames_done != d_snap || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_silent: %0d extra falls, busy %b, required 0 and 0", falls - f_snap, busy);
    end
  endtask

  task automatic test_default_params();
    int t = 0;
    valid2 = 1'b1;
    data2  = 8'hAA;
    tick();
    valid2 = 1'b0;
    while (nb2 < 11 && t < 25000) begin
      tick();
      t++;
    end
    tick(HP2 + 100);
    n_checks++;
    if (bits2 !== exp_frame(8'hAA) || bits2[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL dflt_frame: got %b, required %b", bits2, exp_frame(8'hAA));
    end
    tick(2600);
    n_checks++;
    if (nb2 != 11 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL dflt_end: falls %0d busy %b, required 11 and 0", nb2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_fill_and_full();
    test_random();
    test_reset_midframe();
    test_default_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
